// File: rtl/rcvr_param.sv
// rcvr_param: serial header/body receiver with parametrised widths.
//
// Hunts a one-bit-per-clock serial stream for a HEAD_W-bit header (MATCH,
// LSB received first). After a match it captures the next BODY_W bits,
// MSB first, into a holding register with a ready/overrun host handshake.
//
// Optional build macro: RCVR_PARITY_EN
//   When defined, an even-parity bit follows each body. A word with good
//   parity is delivered one cycle later. A word with bad parity is dropped,
//   and parity_err pulses for one cycle.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   data_in    in   serial bit, sampled every rising edge
//   reading    in   host consumes data_out this cycle
//   ready      out  data_out holds an unread word
//   overrun    out  a new word replaced an unread word
//   in_frame   out  receiver is inside a body (or parity) slot
//   data_out   out  last captured body word, first body bit in the MSB
//   parity_err out  (RCVR_PARITY_EN only) one-cycle bad-parity pulse

module rcvr_param #(
  parameter int unsigned       HEAD_W = 8,
  parameter logic [HEAD_W-1:0] MATCH  = HEAD_W'(8'hA5),
  parameter int unsigned       BODY_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              data_in,
  input  logic              reading,
  output logic              ready,
  output logic              overrun,
  output logic              in_frame,
`ifdef RCVR_PARITY_EN
  output logic              parity_err,
`endif
  output logic [BODY_W-1:0] data_out
);

  localparam int unsigned HCNT_W = $clog2(HEAD_W);
  localparam int unsigned CNT_W  = $clog2(BODY_W);
  localparam int unsigned SR_W   = BODY_W - 1;

  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HEAD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BODY_W - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    BODY = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t              state,    state_d;
  logic [HEAD_W-1:0]   hdr_sr,   hdr_sr_d;
  logic [HCNT_W-1:0]   hdr_cnt,  hdr_cnt_d;
  logic [SR_W-1:0]     body_sr,  body_sr_d;
  logic [CNT_W-1:0]    bit_cnt,  bit_cnt_d;
  logic [BODY_W-1:0]   data_out_d;
  logic                ready_d;
  logic                overrun_d;
  logic                in_frame_d;

  logic [HEAD_W-1:0]   hdr_win_c;
  logic [BODY_W-1:0]   word_c;
  logic                deliver_c;

`ifdef RCVR_PARITY_EN
  logic                last_bit, last_bit_d;
  logic                parity_err_d;
`endif

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      hdr_sr     <= '0;
      hdr_cnt    <= '0;
      body_sr    <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      ready      <= 1'b0;
      overrun    <= 1'b0;
      in_frame   <= 1'b0;
`ifdef RCVR_PARITY_EN
      last_bit   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      hdr_sr     <= hdr_sr_d;
      hdr_cnt    <= hdr_cnt_d;
      body_sr    <= body_sr_d;
      bit_cnt    <= bit_cnt_d;
      data_out   <= data_out_d;
      ready      <= ready_d;
      overrun    <= overrun_d;
      in_frame   <= in_frame_d;
`ifdef RCVR_PARITY_EN
      last_bit   <= last_bit_d;
      parity_err <= parity_err_d;
`endif
    end
  end

  // Next-state, datapath and handshake logic
  always_comb begin
    state_d    = state;
    hdr_sr_d   = hdr_sr;
    hdr_cnt_d  = hdr_cnt;
    body_sr_d  = body_sr;
    bit_cnt_d  = bit_cnt;
    data_out_d = data_out;
    ready_d    = ready;
    overrun_d  = overrun;
    deliver_c  = 1'b0;
    word_c     = {body_sr, data_in};
    // Candidate window: the newest bit lands at the MSB, the oldest sits at bit 0
    hdr_win_c  = {data_in, hdr_sr[HEAD_W-1:1]};
`ifdef RCVR_PARITY_EN
    last_bit_d   = last_bit;
    parity_err_d = 1'b0;
`endif

    case (state)
      HUNT: begin
        hdr_sr_d = hdr_win_c;
        if (hdr_cnt != HCNT_MAX) begin
          hdr_cnt_d = hdr_cnt + 1'b1;
        end
        // hdr_cnt at max means the window plus this bit covers HEAD_W bits
        if ((hdr_cnt == HCNT_MAX) && (hdr_win_c == MATCH)) begin
          state_d   = BODY;
          bit_cnt_d = '0;
        end
      end

      BODY: begin
        body_sr_d = SR_W'({body_sr, data_in});
        bit_cnt_d = bit_cnt + 1'b1;
        if (bit_cnt == CNT_LAST) begin
          // Headers never overlap bodies: the hunt restarts from empty
          bit_cnt_d = '0;
          hdr_sr_d  = '0;
          hdr_cnt_d = '0;
`ifdef RCVR_PARITY_EN
          body_sr_d  = body_sr;
          last_bit_d = data_in;
          state_d    = PAR;
`else
          deliver_c  = 1'b1;
          state_d    = HUNT;
`endif
        end
      end

`ifdef RCVR_PARITY_EN
      PAR: begin
        word_c  = {body_sr, last_bit};
        state_d = HUNT;
        // Even parity: the word bits plus the parity bit XOR to zero
        if ((^word_c) ^ data_in) begin
          parity_err_d = 1'b1;
        end else begin
          deliver_c = 1'b1;
        end
      end
`endif

      default: begin
        state_d = HUNT;
      end
    endcase

    // Delivery wins over a read for ready; a read wins over overrun setting
    if (deliver_c) begin
      data_out_d = word_c;
      ready_d    = 1'b1;
      if (reading) begin
        overrun_d = 1'b0;
      end else if (ready) begin
        overrun_d = 1'b1;
      end
    end else if (reading) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end

    in_frame_d = (state_d != HUNT);
  end

endmodule

// File: doc/rcvr_param.md
Name: rcvr_param

Overview:
- Parametrised successor to the team's fixed 8-bit header/body serial receiver.
- Hunts a 1-bit serial stream for a configurable HEAD_W-bit header. On a match it captures the next BODY_W bits as one word and presents the word in a holding register.
- Holding register uses ready/overrun host handshake semantics.
- Sits between a bit-level line interface and a word-level consumer; one bit per clock.

Parameters:
- HEAD_W, 8, header length in bits (>=2).
- MATCH, 8'hA5, header pattern [HEAD_W-1:0]; MATCH[0] is the first header bit received.
- BODY_W, 8, body length in bits (>=2).

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  1  serial bit, sampled every rising edge.
- reading  input  1  host is consuming data_out this cycle.
- ready  output  1  data_out holds an unread word.
- overrun  output  1  a new word replaced an unread word.
- in_frame  output  1  FSM is in BODY (or PAR) state.
- data_out  output  BODY_W  last captured body word; first body bit received is the MSB.

Behaviour:
- Reset (async assert, sync-safe release), all to 0: FSM=HUNT, ready, overrun, in_frame, hdr_cnt, body counter, data_out.
- HUNT state:
  - Header window hdr_sr[HEAD_W-1:0] shifts right with data_in entering at MSB, so the oldest bit sits at bit 0.
  - hdr_cnt counts bits shifted since HUNT entry and saturates at HEAD_W-1.
  - Match condition this cycle: hdr_cnt==HEAD_W-1 and {data_in, hdr_sr[HEAD_W-1:1]}==MATCH.
  - Overlapping partial headers are found naturally (sliding window); no fallback table.
  - On match: next state BODY, bit counter=0.
- BODY state:
  - Shift data_in left into body_sr (BODY_W-1 bits) and increment the counter.
  - When counter==BODY_W-1 (last body bit): load data_out <= {body_sr, data_in}.
  - Next state: HUNT with hdr_cnt=0 and hdr_sr cleared. A header may not overlap a body.
- Word delivery, on the edge that loads data_out:
  - ready<=1.
  - If ready was already 1 and reading==0, overrun<=1.
- Other cycles:
  - reading==1 clears ready.
  - reading==1 clears overrun, with priority over setting it.
  - Delivery sets ready with priority over the reading clear.
- Latency: data_out and ready are valid on the edge that samples the final body bit (in the non-parity build).
- in_frame is registered and equals (state!=HUNT).
- Minimum frame spacing is HEAD_W+BODY_W cycles; back-to-back frames are accepted with no gap.
- reset_n low mid-frame: the partial word is discarded and data_out returns to 0.
- Widths:
  - Counter width is $clog2(BODY_W).
  - hdr_cnt width is $clog2(HEAD_W).
  - No truncation warnings are permitted at the defaults or at BODY_W=32, HEAD_W=16.

Optional Feature:
- Macro RCVR_PARITY_EN.
- Defined:
  - Extra state PAR follows the last body bit. That bit's cycle loads nothing; the word is held in body_sr plus the final bit.
  - The PAR-cycle data_in is the even-parity bit: XOR of body bits and parity bit must be 0.
  - Good parity: delivery as above, one cycle later than without the macro.
  - Bad parity: data_out, ready and overrun are unchanged; output port parity_err (1 bit, reset 0) pulses high for one cycle.
  - Return to HUNT in both cases.
- Undefined: no PAR state, no parity_err port; behaviour exactly as in Behaviour.

Test Plan:
- Defaults; stream 1,0,1,0,0,1,0,1 (A5, LSB first) then 1,1,0,0,0,0,1,1 -> data_out=8'hC3, ready=1 on the final body edge, overrun=0, in_frame high for 8 cycles.
- Stream 1,0,1,0,1,0,0,1,0,1 + body 8'h0F (partial header overlap) -> match at the 10th bit, data_out=8'h0F.
- Two back-to-back frames, body 8'h12 then 8'h34, reading=0 throughout -> data_out=8'h34, ready=1, overrun=1. Then reading=1 for one cycle -> ready=0, overrun=0.
- reading=1 asserted in the same cycle as delivery of 8'h55 with ready=1 -> ready stays 1, overrun stays 0, data_out=8'h55.
- reset_n pulsed low asynchronously (between edges) at body bit 4 -> all outputs 0 immediately. The next full frame with body 8'hA0 delivers data_out=8'hA0.
- RCVR_PARITY_EN, body 8'h03 with parity 0 -> delivered one cycle later. Body 8'h03 with parity 1 -> parity_err pulses 1 cycle, ready unchanged.
